// File: rtl/exception_ctrl_if.sv
// MEM-stage exception bus between the pipeline/CP0 side and exception_ctrl.
// The master drives pipeline and CP0 state; the slave is the arbiter,
// which returns the CP0 exception inputs, the flush/redirect and the
// synchronised interrupt lines.
interface exception_ctrl_if;
   // interrupt lines
   logic [5:0]  ext_int_i;
   logic [5:0]  int_o;

   // MEM-stage instruction
   logic        inst_valid_i;
   logic        stall_i;
   logic [31:0] pc_i;
   logic        is_in_delayslot_i;
   logic [31:0] mem_addr_i;

   // exception flags carried down the pipeline
   logic        exc_fetch_adel_i;
   logic        exc_ri_i;
   logic        exc_ov_i;
   logic        exc_syscall_i;
   logic        exc_break_i;
   logic        exc_trap_i;
   logic        exc_load_ade_i;
   logic        exc_store_ade_i;
   logic        eret_i;

   // CP0 state and the WB-stage mtc0 in flight
   logic [31:0] cp0_status_i;
   logic [31:0] cp0_cause_i;
   logic [31:0] cp0_epc_i;
   logic        wb_cp0_we_i;
   logic [4:0]  wb_cp0_waddr_i;
   logic [31:0] wb_cp0_data_i;

   // results towards CP0 and the pipeline
   logic [31:0] excepttype_o;
   logic [31:0] current_inst_addr_o;
   logic        is_in_delayslot_o;
   logic [31:0] bad_addr_o;
   logic        flush_o;
   logic [31:0] new_pc_o;

   modport master (
      output ext_int_i, inst_valid_i, stall_i, pc_i, is_in_delayslot_i,
             mem_addr_i, exc_fetch_adel_i, exc_ri_i, exc_ov_i,
             exc_syscall_i, exc_break_i, exc_trap_i, exc_load_ade_i,
             exc_store_ade_i, eret_i, cp0_status_i, cp0_cause_i, cp0_epc_i,
             wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_data_i,
      input  int_o, excepttype_o, current_inst_addr_o, is_in_delayslot_o,
             bad_addr_o, flush_o, new_pc_o
   );

   modport slave (
      input  ext_int_i, inst_valid_i, stall_i, pc_i, is_in_delayslot_i,
             mem_addr_i, exc_fetch_adel_i, exc_ri_i, exc_ov_i,
             exc_syscall_i, exc_break_i, exc_trap_i, exc_load_ade_i,
             exc_store_ade_i, eret_i, cp0_status_i, cp0_cause_i, cp0_epc_i,
             wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_data_i,
      output int_o, excepttype_o, current_inst_addr_o, is_in_delayslot_o,
             bad_addr_o, flush_o, new_pc_o
   );
endinterface

// File: rtl/exception_ctrl.sv
// MEM-stage exception arbiter feeding CP0.
// Merges pipeline exception flags with the (bypassed) interrupt state,
// reports one winning exception per committing instruction, raises the
// pipeline flush with its redirect PC, and synchronises the external
// interrupt lines that CP0 latches into Cause[15:10].
module exception_ctrl #(
   parameter logic [31:0] EXC_VECTOR  = 32'hBFC00380,
   parameter int          SYNC_STAGES = 2
) (
   input logic          clk,
   input logic          rst,
   exception_ctrl_if.slave bus
);

   // CP0 register numbers that the WB-stage mtc0 can target
   localparam logic [4:0] CP0_STATUS = 5'd12;
   localparam logic [4:0] CP0_CAUSE  = 5'd13;
   localparam logic [4:0] CP0_EPC    = 5'd14;

   // excepttype codes handed to CP0
   localparam logic [31:0] EXC_NONE = 32'h0000_0000;
   localparam logic [31:0] EXC_INT  = 32'h0000_0001;
   localparam logic [31:0] EXC_ADEL = 32'h0000_0004;
   localparam logic [31:0] EXC_ADES = 32'h0000_0005;
   localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
   localparam logic [31:0] EXC_BRK  = 32'h0000_0009;
   localparam logic [31:0] EXC_RI   = 32'h0000_000a;
   localparam logic [31:0] EXC_OV   = 32'h0000_000c;
   localparam logic [31:0] EXC_TRAP = 32'h0000_000d;
   localparam logic [31:0] EXC_ERET = 32'h0000_000e;

   // RUN: exceptions recognised; FLUSH: one dead cycle while CP0 updates
   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_FLUSH = 1'b1
   } state_t;

   state_t      state;

   logic [5:0]  sync_q [SYNC_STAGES];

   logic [31:0] status_eff;
   logic [7:0]  cause_ip;
   logic [31:0] epc_eff;
   logic        int_pending;

   logic [31:0] exc_code;
   logic [31:0] exc_bad_addr;
   logic        recognise;
   logic        commit;

   logic        unused_bits;

   // External interrupt synchroniser: a plain flop chain per line
   // NOTE: every stage is reset so int_o is clean the moment reset releases.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         // NOTE: non-blocking so each stage takes its neighbour's old value.
         sync_q[0] <= bus.ext_int_i;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign bus.int_o = sync_q[SYNC_STAGES-1];

   // Bypass the WB-stage mtc0 so a write one cycle ahead is already seen.
   // Only the software-interrupt bits of Cause are writable by mtc0.
   always_comb begin
      status_eff = bus.cp0_status_i;
      cause_ip   = bus.cp0_cause_i[15:8];
      epc_eff    = bus.cp0_epc_i;
      if (bus.wb_cp0_we_i) begin
         case (bus.wb_cp0_waddr_i)
            CP0_STATUS: status_eff    = bus.wb_cp0_data_i;
            CP0_CAUSE:  cause_ip[1:0] = bus.wb_cp0_data_i[9:8];
            CP0_EPC:    epc_eff       = bus.wb_cp0_data_i;
            default:    ;
         endcase
      end
   end

   // Interrupt pending: IE set, EXL clear, some unmasked IP bit asserted
   assign int_pending = status_eff[0] & ~status_eff[1]
                      & (|(cause_ip & status_eff[15:8]));

   // Fixed-priority pick of the winning exception and its bad address
   always_comb begin
      // NOTE: defaults first so every path assigns both outputs; no latch.
      exc_code     = EXC_NONE;
      exc_bad_addr = '0;
      if (int_pending) begin
         exc_code = EXC_INT;
      end else if (bus.exc_fetch_adel_i) begin
         exc_code     = EXC_ADEL;
         exc_bad_addr = bus.pc_i;
      end else if (bus.exc_ri_i) begin
         exc_code = EXC_RI;
      end else if (bus.exc_ov_i) begin
         exc_code = EXC_OV;
      end else if (bus.exc_trap_i) begin
         exc_code = EXC_TRAP;
      end else if (bus.exc_syscall_i) begin
         exc_code = EXC_SYS;
      end else if (bus.exc_break_i) begin
         exc_code = EXC_BRK;
      end else if (bus.exc_load_ade_i) begin
         exc_code     = EXC_ADEL;
         exc_bad_addr = bus.mem_addr_i;
      end else if (bus.exc_store_ade_i) begin
         exc_code     = EXC_ADES;
         exc_bad_addr = bus.mem_addr_i;
      end else if (bus.eret_i) begin
         exc_code = EXC_ERET;
      end
   end

   // A stalled instruction is re-evaluated each cycle but only commits
   // once it is free to leave MEM; the FLUSH cycle blocks a double commit.
   assign recognise = bus.inst_valid_i & ~bus.stall_i & (state == ST_RUN);
   assign commit    = recognise & (exc_code != EXC_NONE);

   assign bus.excepttype_o        = commit ? exc_code : EXC_NONE;
   assign bus.bad_addr_o          = commit ? exc_bad_addr : '0;
   assign bus.flush_o             = commit;
   assign bus.new_pc_o            = !commit               ? '0 :
                                    (exc_code == EXC_ERET) ? epc_eff :
                                                             EXC_VECTOR;
   // CP0 does the EPC adjustment, so the raw PC and slot flag go through.
   assign bus.current_inst_addr_o = bus.pc_i;
   assign bus.is_in_delayslot_o   = bus.is_in_delayslot_i;

   // RUN/FLUSH sequencing; a stall freezes the state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_RUN;
      end else if (!bus.stall_i) begin
         case (state)
            ST_RUN:   if (commit) state <= ST_FLUSH;
            ST_FLUSH: state <= ST_RUN;
            default:  state <= ST_RUN;
         endcase
      end
   end

   // Status/Cause fields this block has no use for
   assign unused_bits = ^{status_eff[31:16], status_eff[7:2],
                          bus.cp0_cause_i[31:16], bus.cp0_cause_i[7:0]};

endmodule

// File: tb/tb_exception_ctrl.sv
// Self-checking bench for exception_ctrl: reference-model random run,
// a table of single-cycle priority/bypass vectors, and hand-written
// sequences for reset, FLUSH, stall and mid-FLUSH reset behaviour.
module tb_exception_ctrl;

   localparam logic [31:0] VEC  = 32'hBFC00380;
   localparam int          SYNC = 2;

   // Priority order from highest; flags[8:0] = fetch,ri,ov,trap,sys,brk,load,store,eret
   localparam logic [31:0] CODES [10] = '{32'h1, 32'h4, 32'ha, 32'hc, 32'hd,
                                          32'h8, 32'h9, 32'h4, 32'h5, 32'he};
   // bad address source: 0 none, 1 pc, 2 mem_addr
   localparam int          ASEL  [10] = '{0, 1, 0, 0, 0, 0, 0, 2, 2, 0};

   logic clk = 1'b0;
   logic rst;
   logic [8:0] flags;

   always #5 clk = ~clk;

   exception_ctrl_if bus ();

   exception_ctrl #(
      .EXC_VECTOR  (VEC),
      .SYNC_STAGES (SYNC)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   assign bus.exc_fetch_adel_i = flags[8];
   assign bus.exc_ri_i         = flags[7];
   assign bus.exc_ov_i         = flags[6];
   assign bus.exc_trap_i       = flags[5];
   assign bus.exc_syscall_i    = flags[4];
   assign bus.exc_break_i      = flags[3];
   assign bus.exc_load_ade_i   = flags[2];
   assign bus.exc_store_ade_i  = flags[1];
   assign bus.eret_i           = flags[0];

   typedef struct {
      logic [31:0] code;
      logic        flush;
      logic [31:0] new_pc;
      logic [31:0] bad;
   } exp_t;

   typedef struct {
      string       name;
      logic        valid;
      logic [8:0]  flags;
      logic [31:0] pc;
      logic [31:0] mem;
      logic [31:0] status;
      logic [31:0] cause;
      logic [31:0] epc;
      logic        we;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic [31:0] exp_code;
      logic [31:0] exp_bad;
      logic [31:0] exp_pc;
   } vec_t;

   int checks = 0;
   int errors = 0;

   // model state: in the one-cycle post-commit window, and sync history
   bit         m_flush;
   logic [5:0] hist [SYNC];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model computed directly from the priority/bypass rules
   function automatic exp_t model_eval(input bit in_flush);
      exp_t        e;
      logic [31:0] st, ca, ep;
      bit          hit [10];
      bit          irq;
      int          win;
      st = bus.cp0_status_i;
      ca = bus.cp0_cause_i;
      ep = bus.cp0_epc_i;
      if (bus.wb_cp0_we_i && bus.wb_cp0_waddr_i == 5'd12) st = bus.wb_cp0_data_i;
      if (bus.wb_cp0_we_i && bus.wb_cp0_waddr_i == 5'd13) ca[9:8] = bus.wb_cp0_data_i[9:8];
      if (bus.wb_cp0_we_i && bus.wb_cp0_waddr_i == 5'd14) ep = bus.wb_cp0_data_i;
      irq = st[0] && !st[1] && ((ca[15:8] & st[15:8]) != 8'h00);
      hit[0] = irq;
      for (int k = 1; k < 10; k++) hit[k] = flags[9-k];
      win = -1;
      for (int k = 9; k >= 0; k--) if (hit[k]) win = k;
      e = '{32'h0, 1'b0, 32'h0, 32'h0};
      if (bus.inst_valid_i && !bus.stall_i && !in_flush && win >= 0) begin
         e.code   = CODES[win];
         e.flush  = 1'b1;
         e.new_pc = (CODES[win] == 32'he) ? ep : VEC;
         e.bad    = (ASEL[win] == 1) ? bus.pc_i :
                    (ASEL[win] == 2) ? bus.mem_addr_i : 32'h0;
      end
      return e;
   endfunction

   task automatic compare_model();
      exp_t e;
      e = model_eval(m_flush);
      check("excepttype", bus.excepttype_o, e.code);
      check("flush", {31'h0, bus.flush_o}, {31'h0, e.flush});
      check("new_pc", bus.new_pc_o, e.new_pc);
      check("bad_addr", bus.bad_addr_o, e.bad);
      check("int_o", {26'h0, bus.int_o}, {26'h0, hist[SYNC-1]});
      check("cur_addr", bus.current_inst_addr_o, bus.pc_i);
      check("delayslot", {31'h0, bus.is_in_delayslot_o}, {31'h0, bus.is_in_delayslot_i});
   endtask

   // Called at the negative edge: step the model across the next rising edge
   task automatic advance();
      exp_t e;
      e = model_eval(m_flush);
      @(posedge clk);
      if (!rst) begin
         m_flush = 1'b0;
         for (int i = 0; i < SYNC; i++) hist[i] = '0;
      end else begin
         if (!bus.stall_i) m_flush = (e.code != 32'h0);
         for (int i = SYNC - 1; i > 0; i--) hist[i] = hist[i-1];
         hist[0] = bus.ext_int_i;
      end
      #1;
   endtask

   task automatic cycle();
      @(negedge clk);
      compare_model();
      advance();
   endtask

   task automatic quiet();
      bus.inst_valid_i = 1'b0;
      bus.stall_i      = 1'b0;
      bus.wb_cp0_we_i  = 1'b0;
      bus.cp0_status_i = '0;
      bus.cp0_cause_i  = '0;
      bus.cp0_epc_i    = '0;
      flags            = '0;
   endtask

   task automatic apply(input vec_t v, input logic ds);
      bus.inst_valid_i      = v.valid;
      flags                 = v.flags;
      bus.pc_i              = v.pc;
      bus.mem_addr_i        = v.mem;
      bus.cp0_status_i      = v.status;
      bus.cp0_cause_i       = v.cause;
      bus.cp0_epc_i         = v.epc;
      bus.wb_cp0_we_i       = v.we;
      bus.wb_cp0_waddr_i    = v.waddr;
      bus.wb_cp0_data_i     = v.wdata;
      bus.is_in_delayslot_i = ds;
      bus.stall_i           = 1'b0;
   endtask

   vec_t vecs [20];

   initial begin
      //        name                  vld flags   pc            mem           status        cause         epc           we waddr wdata         code   bad           new_pc
      vecs[0]  = '{"irq",              1, 9'h000, 32'hBFC00100, 32'h0,        32'h0000FF01, 32'h00000400, 32'h0,        0, 5'd0,  32'h0,        32'h1, 32'h0,        VEC};
      vecs[1]  = '{"ri_over_ades",     1, 9'h082, 32'hBFC00104, 32'h00000003, 32'h0,        32'h0,        32'h0,        0, 5'd0,  32'h0,        32'ha, 32'h0,        VEC};
      vecs[2]  = '{"ades",             1, 9'h002, 32'hBFC00104, 32'h00000003, 32'h0,        32'h0,        32'h0,        0, 5'd0,  32'h0,        32'h5, 32'h00000003, VEC};
      vecs[3]  = '{"eret_bypass",      1, 9'h001, 32'hBFC00108, 32'h0,        32'h0,        32'h0,        32'hBFC00010, 1, 5'd14, 32'hBFC00200, 32'he, 32'h0,        32'hBFC00200};
      vecs[4]  = '{"status_bypass",    1, 9'h000, 32'hBFC0010C, 32'h0,        32'h0000FF03, 32'h00000400, 32'h0,        1, 5'd12, 32'h0000FF01, 32'h1, 32'h0,        VEC};
      vecs[5]  = '{"fetch_adel",       1, 9'h180, 32'h00000101, 32'h0,        32'h0,        32'h0,        32'h0,        0, 5'd0,  32'h0,        32'h4, 32'h00000101, VEC};
      vecs[6]  = '{"ov_over_trap",     1, 9'h060, 32'hBFC00110, 32'h0,        32'h0,        32'h0,        32'h0,        0, 5'd0,  32'h0,        32'hc, 32'h0,        VEC};
      vecs[7]  = '{"trap_over_sys",    1, 9'h030, 32'hBFC00114, 32'h0,        32'h0,        32'h0,        32'h0,        0, 5'd0,  32'h0,        32'hd, 32'h0,        VEC};
      vecs[8]  = '{"sys_over_brk",     1, 9'h018, 32'hBFC00118, 32'h0,        32'h0,        32'h0,        32'h0,        0, 5'd0,  32'h0,        32'h8, 32'h0,        VEC};
      vecs[9]  = '{"brk_over_load",    1, 9'h00c, 32'hBFC0011C, 32'h00000011, 32'h0,        32'h0,        32'h0,        0, 5'd0,  32'h0,        32'h9, 32'h0,        VEC};
      vecs[10] = '{"load_adel",        1, 9'h006, 32'hBFC00120, 32'h00000011, 32'h0,        32'h0,        32'h0,        0, 5'd0,  32'h0,        32'h4, 32'h00000011, VEC};
      vecs[11] = '{"irq_over_sys",     1, 9'h010, 32'hBFC00124, 32'h0,        32'h0000FF01, 32'h00000400, 32'h0,        0, 5'd0,  32'h0,        32'h1, 32'h0,        VEC};
      vecs[12] = '{"ie_clear",         1, 9'h010, 32'hBFC00128, 32'h0,        32'h0000FF00, 32'h00000400, 32'h0,        0, 5'd0,  32'h0,        32'h8, 32'h0,        VEC};
      vecs[13] = '{"sw_int_bypass",    1, 9'h000, 32'hBFC0012C, 32'h0,        32'h0000FF01, 32'h0,        32'h0,        1, 5'd13, 32'h00000100, 32'h1, 32'h0,        VEC};
      vecs[14] = '{"cause_hw_no_byp",  1, 9'h008, 32'hBFC00130, 32'h0,        32'h0000FF01, 32'h0,        32'h0,        1, 5'd13, 32'h00000400, 32'h9, 32'h0,        VEC};
      vecs[15] = '{"no_exc",           1, 9'h000, 32'hBFC00134, 32'h0,        32'h0,        32'h0,        32'h0,        0, 5'd0,  32'h0,        32'h0, 32'h0,        32'h0};
      vecs[16] = '{"bubble",           0, 9'h010, 32'hBFC00138, 32'h0,        32'h0,        32'h0,        32'h0,        0, 5'd0,  32'h0,        32'h0, 32'h0,        32'h0};
      vecs[17] = '{"eret_epc",         1, 9'h001, 32'hBFC0013C, 32'h0,        32'h0,        32'h0,        32'hBFC00010, 0, 5'd0,  32'h0,        32'he, 32'h0,        32'hBFC00010};
      vecs[18] = '{"exl_blocks",       1, 9'h000, 32'hBFC00140, 32'h0,        32'h0000FF03, 32'h00000400, 32'h0,        0, 5'd0,  32'h0,        32'h0, 32'h0,        32'h0};
      vecs[19] = '{"im_masked",        1, 9'h000, 32'hBFC00144, 32'h0,        32'h0000FB01, 32'h00000400, 32'h0,        0, 5'd0,  32'h0,        32'h0, 32'h0,        32'h0};

      // ---------------- reset and synchroniser latency ----------------
      quiet();
      bus.pc_i = '0; bus.mem_addr_i = '0; bus.is_in_delayslot_i = 1'b0;
      bus.wb_cp0_waddr_i = '0; bus.wb_cp0_data_i = '0;
      bus.ext_int_i = 6'h3F;
      rst = 1'b0;
      #1;
      check("rst_int_o", {26'h0, bus.int_o}, 32'h0);
      check("rst_flush", {31'h0, bus.flush_o}, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      check("rst_int_o_held", {26'h0, bus.int_o}, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      check("sync_edge1", {26'h0, bus.int_o}, 32'h0);
      @(posedge clk); #1;
      check("sync_edge2", {26'h0, bus.int_o}, 32'h3F);
      hist[0] = 6'h3F; hist[1] = 6'h3F;
      m_flush = 1'b0;
      bus.ext_int_i = 6'h00;
      repeat (3) cycle();

      // ---------------- table of single-cycle vectors ----------------
      for (int i = 0; i < 20; i++) begin
         apply(vecs[i], logic'(i % 2));
         @(negedge clk);
         check({vecs[i].name, "_code"}, bus.excepttype_o, vecs[i].exp_code);
         check({vecs[i].name, "_flush"}, {31'h0, bus.flush_o}, {31'h0, vecs[i].exp_code != 32'h0});
         check({vecs[i].name, "_bad"}, bus.bad_addr_o, vecs[i].exp_bad);
         check({vecs[i].name, "_newpc"}, bus.new_pc_o, vecs[i].exp_pc);
         check({vecs[i].name, "_curaddr"}, bus.current_inst_addr_o, vecs[i].pc);
         advance();
         quiet();
         cycle();
      end

      // ---------------- interrupt held: single FLUSH cycle ----------------
      apply(vecs[0], 1'b0);
      @(negedge clk);
      check("held_irq_commit", bus.excepttype_o, 32'h1);
      check("held_irq_newpc", bus.new_pc_o, VEC);
      advance();
      @(negedge clk);
      check("held_flush_cycle_flush", {31'h0, bus.flush_o}, 32'h0);
      check("held_flush_cycle_code", bus.excepttype_o, 32'h0);
      check("held_flush_cycle_newpc", bus.new_pc_o, 32'h0);
      advance();
      @(negedge clk);
      check("held_back_in_run", bus.excepttype_o, 32'h1);
      advance();
      quiet();
      cycle();

      // ---------------- stall holds off the commit ----------------
      apply(vecs[8], 1'b0);
      flags = 9'h010;
      bus.stall_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("stall_code", bus.excepttype_o, 32'h0);
         check("stall_flush", {31'h0, bus.flush_o}, 32'h0);
         advance();
      end
      bus.stall_i = 1'b0;
      @(negedge clk);
      check("unstall_code", bus.excepttype_o, 32'h8);
      check("unstall_flush", {31'h0, bus.flush_o}, 32'h1);
      advance();
      @(negedge clk);
      check("unstall_once", {31'h0, bus.flush_o}, 32'h0);
      advance();
      quiet();
      cycle();

      // ---------------- reset during FLUSH returns to RUN ----------------
      apply(vecs[8], 1'b0);
      flags = 9'h010;
      @(negedge clk);
      check("midflush_commit", {31'h0, bus.flush_o}, 32'h1);
      advance();
      @(negedge clk);
      check("midflush_in_flush", {31'h0, bus.flush_o}, 32'h0);
      #1 rst = 1'b0;
      #1;
      check("midflush_reset_run", bus.excepttype_o, 32'h8);
      check("midflush_reset_flush", {31'h0, bus.flush_o}, 32'h1);
      m_flush = 1'b0;
      for (int i = 0; i < SYNC; i++) hist[i] = '0;
      @(posedge clk); #1;
      rst = 1'b1;
      quiet();
      cycle();
      cycle();

      // ---------------- randomized run against the model ----------------
      for (int n = 0; n < 400; n++) begin
         logic [31:0] st;
         int          sel;
         bus.inst_valid_i      = ($urandom_range(0, 9) < 8);
         bus.stall_i           = ($urandom_range(0, 3) == 0);
         bus.is_in_delayslot_i = 1'($urandom_range(0, 1));
         bus.pc_i              = $urandom;
         bus.mem_addr_i        = $urandom;
         bus.ext_int_i         = 6'($urandom_range(0, 63));
         for (int b = 0; b < 9; b++) flags[b] = ($urandom_range(0, 7) == 0);
         st    = $urandom;
         st[1] = ($urandom_range(0, 3) == 0);
         bus.cp0_status_i  = st;
         bus.cp0_cause_i   = $urandom;
         bus.cp0_epc_i     = $urandom;
         bus.wb_cp0_we_i   = 1'($urandom_range(0, 1));
         sel               = int'($urandom_range(0, 3));
         bus.wb_cp0_waddr_i = (sel == 0) ? 5'd12 : (sel == 1) ? 5'd13 :
                              (sel == 2) ? 5'd14 : 5'($urandom_range(0, 31));
         bus.wb_cp0_data_i = $urandom;
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
